// File: rtl/data_memory_arbiter.sv
// Single-port data RAM arbiter: CPU load/store has priority, host/debug loader
// gets a bounded wait, and host_lock stalls the CPU so programs can be loaded.
module data_memory_arbiter #(
   parameter int ADDR_SIZE     = 18,
   parameter int WORD_SIZE     = 18,
   parameter int HOST_MAX_WAIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [ADDR_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic                 cpu_stall,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [ADDR_SIZE-1:0] host_addr,
   input  logic [WORD_SIZE-1:0] host_wdata,
   input  logic                 host_lock,
   output logic                 host_ack,
   output logic [WORD_SIZE-1:0] host_rdata,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   localparam logic [3:0] MAX_WAIT = 4'(HOST_MAX_WAIT);

   typedef enum logic [1:0] {
      H_IDLE = 2'd0,
      H_WAIT = 2'd1,
      H_ACK  = 2'd2
   } hstate_t;

   hstate_t              state, state_nxt;
   logic [3:0]           wait_cnt, wait_nxt;
   logic                 eligible, grant_host, grant_cpu;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [WORD_SIZE-1:0] wdata_q, cpu_hold, host_hold;
   logic                 cpu_rd_pend, host_we_q;

   // Grants are masked while reset is low so the RAM sees no strobe.
   always_comb begin
      eligible   = host_req && (state != H_ACK);
      grant_host = reset && eligible && (!cpu_req || host_lock || (wait_cnt == MAX_WAIT));
      grant_cpu  = reset && cpu_req && !host_lock && !grant_host;
      cpu_stall  = cpu_req && !grant_cpu;
      host_ack   = (state == H_ACK);
   end

   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = 1'b0;
      if (grant_host) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_we    = host_we;
      end else if (grant_cpu) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end
   end

   // Read data passes straight through in the return cycle, then is held.
   always_comb begin
      cpu_rdata  = cpu_rd_pend ? mem_rdata : cpu_hold;
      host_rdata = (host_ack && !host_we_q) ? mem_rdata : host_hold;
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         H_IDLE: begin
            if (grant_host)    state_nxt = H_ACK;
            else if (eligible) state_nxt = H_WAIT;
         end
         H_WAIT: begin
            if (grant_host)    state_nxt = H_ACK;
            else if (!host_req) state_nxt = H_IDLE;
         end
         H_ACK:   state_nxt = H_IDLE;
         default: state_nxt = H_IDLE;
      endcase
      // The deferral counter includes the first cycle the request is seen.
      if (grant_host || !eligible)  wait_nxt = 4'd0;
      else if (wait_cnt != MAX_WAIT) wait_nxt = wait_cnt + 4'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= H_IDLE;
         wait_cnt    <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_hold    <= '0;
         host_hold   <= '0;
         cpu_rd_pend <= 1'b0;
         host_we_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         addr_q      <= mem_addr;
         wdata_q     <= mem_wdata;
         cpu_rd_pend <= grant_cpu && !cpu_we;
         cpu_hold    <= cpu_rdata;
         host_hold   <= host_rdata;
         if (grant_host) host_we_q <= host_we;
      end
   end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port synchronous data memory between the processor's load/store stage (CPU port) and a host/debug loader (HOST port). One memory access is granted per cycle. The CPU has priority, but a bounded-wait counter guarantees host progress. A lock mode stalls the CPU completely so the host can load programs. The block sits between stage-3 load/store decode and the data RAM, and drives the pipeline stall.

## Interface
- ADDR_SIZE, 18, memory address width
- WORD_SIZE, 18, data word width
- HOST_MAX_WAIT, 4, maximum cycles a pending host request is deferred by CPU traffic (1..15)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_SIZE  CPU address
- cpu_wdata  in  WORD_SIZE  CPU write data
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds request unchanged
- cpu_rdata  out  WORD_SIZE  CPU read data, valid the cycle after the granted read
- host_req  in  1  host request; held until host_ack
- host_we  in  1  host write enable
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  WORD_SIZE  host write data
- host_lock  in  1  stall the CPU unconditionally while high
- host_ack  out  1  one-cycle pulse completing a host access
- host_rdata  out  WORD_SIZE  host read data, valid with host_ack and held afterwards
- mem_addr  out  ADDR_SIZE  RAM address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  WORD_SIZE  RAM write data
- mem_rdata  in  WORD_SIZE  RAM read data, one cycle after the address

## Operation
- Host FSM states:
  - H_IDLE: no host request pending.
  - H_WAIT: host request pending; wait_cnt counts deferred cycles.
  - H_ACK: host granted last cycle; host_ack is asserted this cycle.
- Grant rule, evaluated each cycle. A host request is eligible when host_req=1 and the FSM is not in H_ACK.
  - grant_host = eligible AND (cpu_req=0 OR host_lock=1 OR wait_cnt==HOST_MAX_WAIT).
  - grant_cpu = cpu_req AND NOT host_lock AND NOT grant_host.
- cpu_stall = cpu_req AND NOT grant_cpu. cpu_stall is 0 when cpu_req=0.
- Memory mux:
  - The granted port drives mem_addr, mem_we and mem_wdata.
  - With no grant: mem_we=0, and mem_addr/mem_wdata keep their last values.
- FSM transitions:
  - H_IDLE/H_WAIT → H_ACK on grant_host.
  - H_IDLE → H_WAIT when eligible and not granted.
  - H_ACK → H_IDLE unconditionally.
  - A host_req still high in the H_ACK cycle is ignored that cycle and becomes eligible the next cycle. Host throughput is at most one access per 2 cycles.
- wait_cnt:
  - Increments in H_WAIT on each cycle the host is deferred.
  - Saturates at HOST_MAX_WAIT.
  - Clears on grant_host.
- CPU read return:
  - The cycle after a CPU read grant, cpu_rdata = mem_rdata (combinational pass-through), and mem_rdata is captured into a hold register.
  - In all other cycles cpu_rdata = the hold register.
- Host read return: in H_ACK, host_rdata is loaded from mem_rdata on a read, and is unchanged on a write.
- Simultaneous CPU write and host read of the same address in consecutive cycles: no forwarding. Each access sees RAM contents at its own grant.

## Timing
- Reset (reset=0, asynchronous): FSM → H_IDLE, wait_cnt=0, host_ack=0, host_rdata=0, cpu_rdata hold=0, mem_we=0, mem_addr=0, mem_wdata=0. Outputs cpu_stall=0 while cpu_req=0.
- Reset asserted during H_ACK or H_WAIT: the pending access is discarded and no host_ack is emitted.
- CPU latency: grant in cycle N, read data valid in N+1. A stalled access is performed in the first cycle with cpu_stall=0.
- Host latency:
  - Uncontended: req in cycle N, grant in N, host_ack in N+1.
  - Worst case with continuous CPU traffic: grant in N+HOST_MAX_WAIT, host_ack in N+HOST_MAX_WAIT+1.
- host_lock takes effect in the same cycle it rises, with no delay. When it falls, the CPU is granted that same cycle unless the host is granted.

## Test plan
- CPU write 0x155 to addr 3, then read addr 3, no host activity → cpu_stall=0 in both cycles; cpu_rdata=0x155 in the cycle after the read; cpu_rdata holds 0x155 while idle.
- Host write 0x2AA to addr 10 with the CPU idle → mem_we=1 and mem_addr=10 in cycle N; host_ack=1 for one cycle in N+1; FSM returns to H_IDLE.
- CPU requesting every cycle, host read asserted at cycle 0, HOST_MAX_WAIT=4 → host granted in cycle 4 with cpu_stall=1 that cycle only; host_ack in cycle 5 with correct data.
- host_lock=1 with cpu_req=1 for 6 cycles, host issuing back-to-back writes → cpu_stall=1 all 6 cycles; host grants in cycles 0, 2, 4; host_ack in 1, 3, 5.
- reset pulled low during the H_ACK cycle → host_ack=0 immediately; after release FSM=H_IDLE, wait_cnt=0, all outputs at reset values.
- Host read of addr 7 granted in the cycle right after a CPU write of 0x0FF to addr 7 → host_rdata=0x0FF.
